dot_product_accumulator: RTL and testbench
==========================================

Name: dot_product_accumulator

Overview:
- Downstream consumer of the 4x4 pipelined array multiplier.
- Accumulates the stream of 8-bit products into a dot-product per vector.
- Re-aligns operand-side valid/last markers with the multiplier's pipeline latency, so the upstream driver only tags operand pairs.
- Emits one registered result per vector, with element count and a saturation flag.

Parameters:
- PW, 8: product width; must match multiplier output y.
- AW, 16: accumulator and result width, AW > PW.
- MUL_LAT, 3: multiplier latency in cycles, from operands presented to matching y valid; 1..8.
- CW, 8: element-counter width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- op_valid  input  1  an operand pair is presented to the multiplier this cycle.
- op_last  input  1  the pair is the last of its vector; ignored when op_valid=0.
- y  input  PW  multiplier product.
- acc_out  output  AW  completed dot-product.
- elem_count  output  CW  number of products in the completed vector; saturates at 2^CW-1.
- out_valid  output  1  one-cycle pulse when acc_out/elem_count/overflow are updated.
- overflow  output  1  the completed vector saturated.
- busy  output  1  a vector is open or products are in flight.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0, every register clears: delay line, accumulator, counter, state, acc_out, elem_count, out_valid, overflow, busy.
- Delay line: a MUL_LAT-deep shift register carries {op_valid, op_last&op_valid}. Its output pair is {dv, dl}.
  - dv is high exactly in the cycle in which y holds the product of the pair tagged MUL_LAT cycles earlier.
  - y is sampled only at edges where dv=1; y is don't-care otherwise.
- State machine:
  - IDLE (no open vector):
    - dv=1, dl=0: acc=y, cnt=1, ovf=0, go to ACCUM.
    - dv=1, dl=1 (single-element vector): publish y as the result, stay in IDLE.
  - ACCUM:
    - dv=1, dl=0: acc=sat(acc+y), cnt=sat(cnt+1).
    - dv=1, dl=1: publish sat(acc+y) and sat(cnt+1), go to IDLE.
    - dv=0: hold all state (gaps allowed anywhere in a vector).
- Publish: acc_out, elem_count and overflow are registered at the publishing edge. out_valid is high for exactly the following cycle, then returns to 0. Outputs hold their values until the next publish.
- Latency: op_last presented in cycle c -> out_valid high in cycle c+MUL_LAT+1.
- Back-to-back vectors: a new first product may arrive in the cycle right after the publishing edge, with no bubble. The new vector starts from y, not from the old acc.
- Arithmetic:
  - Unsigned; y is zero-extended to AW.
  - If acc+y > 2^AW-1, acc becomes 2^AW-1 and the vector's sticky ovf is set.
  - ovf is cleared when a new vector starts.
- busy = (state==ACCUM) OR any delay-line valid bit set.
- Reset mid-operation drops all in-flight and open-vector data; no out_valid results from it.
- The first vector after reset release is accumulated cleanly.

Test Plan:
- Reset: hold rst_n=0 with op_valid=1 toggling -> acc_out=0, elem_count=0, out_valid=0, overflow=0, busy=0 throughout.
- Three-element vector, back-to-back: pairs (15,15),(15,12),(2,15), i.e. y=225,180,30, with op_last on the third pair in cycle c -> out_valid single pulse at c+4 (MUL_LAT=3), acc_out=435, elem_count=3, overflow=0.
- Single element: (15,15) with op_valid=op_last=1 from IDLE -> acc_out=225, elem_count=1, out_valid one cycle.
- Gaps and back-to-back vectors:
  - Stimulus: vector A = 225, idle cycle, 180 (last); vector B = 30 (last), presented in the cycle immediately after A's last pair.
  - Required response: two out_valid pulses in consecutive cycles; A publishes 405 with count 2, then B publishes 30 with count 1.
- Overflow, with AW=10: five (15,15) pairs, last on the fifth -> acc_out=1023, overflow=1, elem_count=5. The next vector {30} yields acc_out=30, overflow=0.
- Reset mid-vector: two pairs issued, rst_n pulsed low before dv rises -> no out_valid, busy=0. The following {225,180} vector yields 405.

Source files
------------

// File: rtl/dot_product_accumulator.sv
// Accumulates a multiplier product stream into one saturating dot-product per tagged vector.
// Result pulses MUL_LAT+1 cycles after op_last; no backpressure, a product is consumed every cycle it is valid.
module dot_product_accumulator #(
   parameter int PW      = 8,
   parameter int AW      = 16,
   parameter int MUL_LAT = 3,
   parameter int CW      = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          op_valid,
   input  logic          op_last,
   input  logic [PW-1:0] y,
   output logic [AW-1:0] acc_out,
   output logic [CW-1:0] elem_count,
   output logic          out_valid,
   output logic          overflow,
   output logic          busy
);

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t               state;
   logic [MUL_LAT-1:0]   v_sr;
   logic [MUL_LAT-1:0]   l_sr;
   logic [MUL_LAT-1:0]   v_nxt;
   logic [MUL_LAT-1:0]   l_nxt;
   logic [AW-1:0]        acc;
   logic [CW-1:0]        cnt;
   logic                 ovf;
   logic                 dv;
   logic                 dl;
   logic [AW-1:0]        y_ext;
   logic [AW:0]          sum;
   logic                 sum_ovf;
   logic [AW-1:0]        sum_sat;
   logic [CW-1:0]        cnt_inc;
   logic                 accum_nxt;

   // Operand tags travel alongside the multiplier pipeline so dv lines up with y.
   assign v_nxt   = (v_sr << 1) | MUL_LAT'(op_valid);
   assign l_nxt   = (l_sr << 1) | MUL_LAT'(op_valid & op_last);
   assign dv      = v_sr[MUL_LAT-1];
   assign dl      = l_sr[MUL_LAT-1];

   assign y_ext   = {{(AW-PW){1'b0}}, y};
   assign sum     = {1'b0, acc} + {1'b0, y_ext};
   assign sum_ovf = sum[AW];
   assign sum_sat = sum_ovf ? {AW{1'b1}} : sum[AW-1:0];
   assign cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);

   // Next-cycle ACCUM occupancy, so busy can be registered without lagging.
   assign accum_nxt = (state == ACCUM) ? !(dv && dl) : (dv && !dl);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         v_sr       <= '0;
         l_sr       <= '0;
         acc        <= '0;
         cnt        <= '0;
         ovf        <= 1'b0;
         acc_out    <= '0;
         elem_count <= '0;
         out_valid  <= 1'b0;
         overflow   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         v_sr      <= v_nxt;
         l_sr      <= l_nxt;
         out_valid <= 1'b0;
         busy      <= (|v_nxt) | accum_nxt;
         if (dv) begin
            case (state)
               IDLE: begin
                  if (dl) begin
                     acc_out    <= y_ext;
                     elem_count <= CW'(1);
                     overflow   <= 1'b0;
                     out_valid  <= 1'b1;
                  end else begin
                     acc   <= y_ext;
                     cnt   <= CW'(1);
                     ovf   <= 1'b0;
                     state <= ACCUM;
                  end
               end
               ACCUM: begin
                  acc <= sum_sat;
                  cnt <= cnt_inc;
                  ovf <= ovf | sum_ovf;
                  if (dl) begin
                     acc_out    <= sum_sat;
                     elem_count <= cnt_inc;
                     overflow   <= ovf | sum_ovf;
                     out_valid  <= 1'b1;
                     state      <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Directed bench: a 3-stage multiplier model feeds y; a per-cycle table plus reset sequences check the outputs.
module tb_dot_product_accumulator;

   localparam int PW      = 8;
   localparam int AW      = 10;
   localparam int MUL_LAT = 3;
   localparam int CW      = 8;

   logic          clk      = 1'b0;
   logic          rst_n    = 1'b0;
   logic          op_valid = 1'b0;
   logic          op_last  = 1'b0;
   logic [3:0]    a        = '0;
   logic [3:0]    b        = '0;
   logic [PW-1:0] p1       = '0;
   logic [PW-1:0] p2       = '0;
   logic [PW-1:0] y        = '0;
   logic [AW-1:0] acc_out;
   logic [CW-1:0] elem_count;
   logic          out_valid;
   logic          overflow;
   logic          busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       v;
      logic       l;
      logic       e_ov;
      int         e_acc;
      int         e_cnt;
      logic       e_ovf;
      logic       e_busy;
   } vec_t;

   vec_t tbl[$];

   dot_product_accumulator #(.PW(PW), .AW(AW), .MUL_LAT(MUL_LAT), .CW(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .op_valid   (op_valid),
      .op_last    (op_last),
      .y          (y),
      .acc_out    (acc_out),
      .elem_count (elem_count),
      .out_valid  (out_valid),
      .overflow   (overflow),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Behavioural 4x4 multiplier with MUL_LAT=3 register stages.
   always @(posedge clk) begin
      p1 <= {4'b0, a} * {4'b0, b};
      p2 <= p1;
      y  <= p2;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic row(input int ra, input int rb, input logic v, input logic l,
                      input logic ov, input int acc, input int cnt, input logic ovf, input logic bsy);
      vec_t r;
      r.a = 4'(ra); r.b = 4'(rb); r.v = v; r.l = l;
      r.e_ov = ov; r.e_acc = acc; r.e_cnt = cnt; r.e_ovf = ovf; r.e_busy = bsy;
      tbl.push_back(r);
   endtask

   task automatic idle(input int n, input logic ov, input int acc, input int cnt,
                       input logic ovf, input logic bsy);
      for (int k = 0; k < n; k++) row(0, 0, 1'b0, 1'b0, ov, acc, cnt, ovf, bsy);
   endtask

   task automatic drive(input int ra, input int rb, input logic v, input logic l);
      a = 4'(ra); b = 4'(rb); op_valid = v; op_last = l;
   endtask

   task automatic check_all(input string tag, input logic ov, input int acc, input int cnt,
                            input logic ovf, input logic bsy);
      check({tag, " out_valid"},  32'(out_valid),  32'(ov));
      check({tag, " acc_out"},    32'(acc_out),    acc);
      check({tag, " elem_count"}, 32'(elem_count), cnt);
      check({tag, " overflow"},   32'(overflow),   32'(ovf));
      check({tag, " busy"},       32'(busy),       32'(bsy));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int hit;

      // Three-element vector: 225+180+30, last in row 2 -> pulse in row 6.
      row(15, 15, 1, 0, 0,   0, 0, 0, 0);
      row(15, 12, 1, 0, 0,   0, 0, 0, 1);
      row( 2, 15, 1, 1, 0,   0, 0, 0, 1);
      idle(3,          0,   0, 0, 0, 1);
      idle(1,          1, 435, 3, 0, 0);
      idle(1,          0, 435, 3, 0, 0);
      // Single-element vector from IDLE, last in row 8 -> pulse in row 12.
      row(15, 15, 1, 1, 0, 435, 3, 0, 0);
      idle(3,          0, 435, 3, 0, 1);
      idle(1,          1, 225, 1, 0, 0);
      idle(1,          0, 225, 1, 0, 0);
      // Vector A with a gap, then vector B immediately after A's last pair.
      row(15, 15, 1, 0, 0, 225, 1, 0, 0);
      idle(1,          0, 225, 1, 0, 1);
      row(15, 12, 1, 1, 0, 225, 1, 0, 1);
      row( 2, 15, 1, 1, 0, 225, 1, 0, 1);
      idle(2,          0, 225, 1, 0, 1);
      idle(1,          1, 405, 2, 0, 1);
      idle(1,          1,  30, 1, 0, 0);
      idle(1,          0,  30, 1, 0, 0);
      // Five 225s saturate the 10-bit accumulator, then {30} clears overflow.
      row(15, 15, 1, 0, 0,  30, 1, 0, 0);
      row(15, 15, 1, 0, 0,  30, 1, 0, 1);
      row(15, 15, 1, 0, 0,  30, 1, 0, 1);
      row(15, 15, 1, 0, 0,  30, 1, 0, 1);
      row(15, 15, 1, 1, 0,  30, 1, 0, 1);
      idle(3,          0,  30, 1, 0, 1);
      row( 2, 15, 1, 1, 1, 1023, 5, 1, 0);
      idle(3,          0, 1023, 5, 1, 1);
      idle(1,          1,  30, 1, 0, 0);
      idle(1,          0,  30, 1, 0, 0);

      // Reset held with op_valid toggling: everything stays cleared.
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         drive(15, 15, 1'(i % 2), 1'(i % 3 == 0));
         @(negedge clk);
         check_all($sformatf("reset c%0d", i), 0, 0, 0, 0, 0);
      end
      @(posedge clk); #1;
      drive(0, 0, 0, 0);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);

      for (int i = 0; i < tbl.size(); i++) begin
         @(posedge clk); #1;
         drive(tbl[i].a, tbl[i].b, tbl[i].v, tbl[i].l);
         @(negedge clk);
         check_all($sformatf("row%0d", i), tbl[i].e_ov, tbl[i].e_acc, tbl[i].e_cnt,
                   tbl[i].e_ovf, tbl[i].e_busy);
      end

      // Reset mid-vector, before the first product reaches the accumulator.
      @(posedge clk); #1; drive(15, 15, 1, 0);
      @(posedge clk); #1; drive(15, 12, 1, 0);
      @(posedge clk); #1; drive(0, 0, 0, 0);
      rst_n = 1'b0;
      #1;
      check_all("midreset asserted", 0, 0, 0, 0, 0);
      @(posedge clk); #1; rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check($sformatf("midreset c%0d out_valid", i), 32'(out_valid), 0);
         check($sformatf("midreset c%0d busy", i), 32'(busy), 0);
      end

      // First vector after the mid-vector reset: 225+180, last in cycle c -> pulse at c+4.
      @(posedge clk); #1; drive(15, 15, 1, 0);
      @(posedge clk); #1; drive(15, 12, 1, 1);
      @(posedge clk); #1; drive(0, 0, 0, 0);
      hit = -1;
      for (int k = 1; k <= 10 && hit < 0; k++) begin
         @(negedge clk);
         if (out_valid === 1'b1) hit = k;
      end
      check("post-reset latency", 32'(hit), 32'(MUL_LAT + 1));
      check("post-reset acc_out", 32'(acc_out), 405);
      check("post-reset elem_count", 32'(elem_count), 2);
      check("post-reset overflow", 32'(overflow), 0);
      @(negedge clk);
      check("post-reset pulse width", 32'(out_valid), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
